// File: rtl/pe_result_collector.sv
// pe_result_collector
// Receiving end of the PE result stream. NUM_IC consecutive 6x6 tiles are summed
// element-wise into one of two ping-pong banks. The PE stream cannot be stalled, so
// a tile arriving when the fill bank is still FULL or DRAINING is dropped and
// flagged. Finished banks drain one row per valid/ready handshake.
module pe_result_collector #(
  parameter int NUM_IC = 4,
  parameter int ACC_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [11:0]      result_tile_i [0:5][0:5],
  input  logic [7:0]              result_od_i,
  input  logic [8:0]              result_x_i,
  input  logic [8:0]              result_y_i,
  input  logic                    result_valid_i,
  output logic signed [ACC_W-1:0] out_row_o [0:5],
  output logic [7:0]              out_od_o,
  output logic [8:0]              out_x_o,
  output logic [8:0]              out_y_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_last_o,
  output logic                    overflow_o,
  output logic                    tag_err_o
);

  localparam int CNT_W = $clog2(NUM_IC + 1);

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_SEND = 1'b1
  } drain_state_t;

  // Signed add that clamps to the ACC_W range on every step.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [11:0]      b
  );
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

  // Bank bookkeeping
  bank_state_t              bank_state_r [0:1];
  logic [CNT_W-1:0]         bank_cnt_r   [0:1];
  logic [7:0]               bank_od_r    [0:1];
  logic [8:0]               bank_x_r     [0:1];
  logic [8:0]               bank_y_r     [0:1];
  logic signed [ACC_W-1:0]  bank_data_r  [0:1][0:35];
  logic                     fill_ptr_r;
  logic                     drain_ptr_r;

  // Fill decode
  logic fill_write_s;
  logic fill_first_s;
  logic fill_done_s;
  logic drop_s;
  logic tag_mis_s;

  // Drain FSM
  drain_state_t            drain_state_r;
  drain_state_t            drain_next_s;
  logic [2:0]              row_r;
  logic                    drain_start_s;
  logic                    drain_bank_s;
  logic                    drain_free_s;
  logic                    load_s;
  logic                    load_bank_s;
  logic [2:0]              load_row_s;
  logic signed [ACC_W-1:0] sel_row_s [0:5];

  // Classify an incoming tile by the state of the bank it targets.
  always_comb begin
    fill_write_s = 1'b0;
    fill_first_s = 1'b0;
    fill_done_s  = 1'b0;
    drop_s       = 1'b0;
    tag_mis_s    = 1'b0;
    if (result_valid_i) begin
      case (bank_state_r[fill_ptr_r])
        B_EMPTY: begin
          fill_write_s = 1'b1;
          fill_first_s = 1'b1;
          fill_done_s  = (NUM_IC == 1);
        end
        B_FILLING: begin
          fill_write_s = 1'b1;
          fill_done_s  = (bank_cnt_r[fill_ptr_r] == CNT_W'(NUM_IC - 1));
          tag_mis_s    = (result_od_i != bank_od_r[fill_ptr_r]) ||
                         (result_x_i  != bank_x_r[fill_ptr_r])  ||
                         (result_y_i  != bank_y_r[fill_ptr_r]);
        end
        B_FULL, B_DRAINING: begin
          drop_s = 1'b1;
        end
        default: begin
          drop_s = 1'b1;
        end
      endcase
    end else begin
      fill_write_s = 1'b0;
    end
  end

  // Accumulator storage: first tile overwrites, later tiles add with saturation.
  // Not reset: a bank is only read after an EMPTY-state write has initialised it.
  always_ff @(posedge clk) begin
    if (fill_write_s) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 6; c++) begin
          if (fill_first_s) begin
            bank_data_r[fill_ptr_r][6'(r*6 + c)] <= ACC_W'(result_tile_i[3'(r)][3'(c)]);
          end else begin
            bank_data_r[fill_ptr_r][6'(r*6 + c)] <=
              sat_add(bank_data_r[fill_ptr_r][6'(r*6 + c)], result_tile_i[3'(r)][3'(c)]);
          end
        end
      end
    end
  end

  // Bank states, tile counters, tags, fill pointer and sticky error flags.
  // Fill only touches EMPTY/FILLING banks and drain only FULL/DRAINING ones,
  // so the two never update the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_state_r[b] <= B_EMPTY;
        bank_cnt_r[b]   <= '0;
        bank_od_r[b]    <= 8'd0;
        bank_x_r[b]     <= 9'd0;
        bank_y_r[b]     <= 9'd0;
      end
      fill_ptr_r <= 1'b0;
      overflow_o <= 1'b0;
      tag_err_o  <= 1'b0;
    end else begin
      if (fill_write_s) begin
        if (fill_first_s) begin
          bank_od_r[fill_ptr_r]  <= result_od_i;
          bank_x_r[fill_ptr_r]   <= result_x_i;
          bank_y_r[fill_ptr_r]   <= result_y_i;
          bank_cnt_r[fill_ptr_r] <= CNT_W'(1);
        end else begin
          bank_cnt_r[fill_ptr_r] <= bank_cnt_r[fill_ptr_r] + CNT_W'(1);
        end
        if (fill_done_s) begin
          bank_state_r[fill_ptr_r] <= B_FULL;
          fill_ptr_r               <= ~fill_ptr_r;
        end else begin
          bank_state_r[fill_ptr_r] <= B_FILLING;
        end
      end
      if (drop_s) begin
        overflow_o <= 1'b1;
      end
      if (tag_mis_s) begin
        tag_err_o <= 1'b1;
      end
      if (drain_start_s) begin
        bank_state_r[drain_bank_s] <= B_DRAINING;
      end
      if (drain_free_s) begin
        bank_state_r[drain_ptr_r] <= B_EMPTY;
      end
    end
  end

  // Drain FSM next state: pick up FULL banks and step rows on each handshake.
  always_comb begin
    drain_next_s  = drain_state_r;
    drain_start_s = 1'b0;
    drain_bank_s  = drain_ptr_r;
    drain_free_s  = 1'b0;
    load_s        = 1'b0;
    load_bank_s   = drain_ptr_r;
    load_row_s    = row_r;
    case (drain_state_r)
      D_IDLE: begin
        if (bank_state_r[drain_ptr_r] == B_FULL) begin
          drain_next_s  = D_SEND;
          drain_start_s = 1'b1;
          load_s        = 1'b1;
          load_row_s    = 3'd0;
        end else begin
          drain_next_s = D_IDLE;
        end
      end
      D_SEND: begin
        if (out_valid_o && out_ready_i) begin
          if (row_r == 3'd5) begin
            drain_free_s = 1'b1;
            if (bank_state_r[~drain_ptr_r] == B_FULL) begin
              // Chain straight into the other bank with no idle cycle.
              drain_start_s = 1'b1;
              drain_bank_s  = ~drain_ptr_r;
              load_s        = 1'b1;
              load_bank_s   = ~drain_ptr_r;
              load_row_s    = 3'd0;
            end else begin
              drain_next_s = D_IDLE;
            end
          end else begin
            load_s     = 1'b1;
            load_row_s = row_r + 3'd1;
          end
        end else begin
          drain_next_s = D_SEND;
        end
      end
      default: begin
        drain_next_s = D_IDLE;
      end
    endcase
  end

  // Select the row about to be presented.
  always_comb begin
    for (int c = 0; c < 6; c++) begin
      sel_row_s[c] = bank_data_r[load_bank_s][6'(load_row_s) * 6'd6 + 6'(c)];
    end
  end

  // Drain state register and registered output row/tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_state_r <= D_IDLE;
      drain_ptr_r   <= 1'b0;
      row_r         <= 3'd0;
      out_valid_o   <= 1'b0;
      out_last_o    <= 1'b0;
      out_od_o      <= 8'd0;
      out_x_o       <= 9'd0;
      out_y_o       <= 9'd0;
      for (int c = 0; c < 6; c++) begin
        out_row_o[c] <= '0;
      end
    end else begin
      drain_state_r <= drain_next_s;
      out_valid_o   <= (drain_next_s == D_SEND);
      if (drain_free_s) begin
        drain_ptr_r <= ~drain_ptr_r;
      end
      if (load_s) begin
        row_r      <= load_row_s;
        out_od_o   <= bank_od_r[load_bank_s];
        out_x_o    <= bank_x_r[load_bank_s];
        out_y_o    <= bank_y_r[load_bank_s] + 9'(load_row_s);
        out_last_o <= (load_row_s == 3'd5);
        for (int c = 0; c < 6; c++) begin
          out_row_o[c] <= sel_row_s[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// Testbench for pe_result_collector (NUM_IC=4, ACC_W=13 so saturation is reachable).
// Stimulus pushes expected rows into a queue; a negedge monitor pops and compares
// on every handshake and checks that stalled rows stay stable.
module tb_pe_result_collector;

  localparam int NUM_IC = 4;
  localparam int ACC_W  = 13;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [11:0]      result_tile_i [0:5][0:5];
  logic [7:0]              result_od_i;
  logic [8:0]              result_x_i;
  logic [8:0]              result_y_i;
  logic                    result_valid_i;
  logic signed [ACC_W-1:0] out_row_o [0:5];
  logic [7:0]              out_od_o;
  logic [8:0]              out_x_o;
  logic [8:0]              out_y_o;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic                    out_last_o;
  logic                    overflow_o;
  logic                    tag_err_o;

  pe_result_collector #(.NUM_IC(NUM_IC), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .result_tile_i(result_tile_i), .result_od_i(result_od_i),
    .result_x_i(result_x_i), .result_y_i(result_y_i),
    .result_valid_i(result_valid_i),
    .out_row_o(out_row_o), .out_od_o(out_od_o), .out_x_o(out_x_o),
    .out_y_o(out_y_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_o(out_last_o), .overflow_o(overflow_o), .tag_err_o(tag_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][12:0] v;
    logic [7:0]       od;
    logic [8:0]       x;
    logic [8:0]       y;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rows_seen = 0;

  // monitor state
  exp_t                    mon_e;
  bit                      held;
  bit                      bad;
  logic signed [ACC_W-1:0] prev_row [0:5];
  logic [7:0]              prev_od;
  logic [8:0]              prev_x;
  logic [8:0]              prev_y;
  logic                    prev_last;

  function automatic int sat13(input int a);
    if (a > 4095) return 4095;
    if (a < -4096) return -4096;
    return a;
  endfunction

  function automatic int tile_val(input int pat, input int v, input int r, input int c);
    return (pat != 0) ? (r*10 + c - 20) : v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive_tile(input int pat, input int v, input logic [7:0] od,
                            input logic [8:0] x, input logic [8:0] y);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        result_tile_i[r][c] = 12'(tile_val(pat, v, r, c));
    result_od_i = od; result_x_i = x; result_y_i = y;
    result_valid_i = 1'b1;
    @(posedge clk); #1;
    result_valid_i = 1'b0;
  endtask

  task automatic send_group(input int pat, input int v, input logic [7:0] od,
                            input logic [8:0] x, input logic [8:0] y);
    for (int t = 0; t < NUM_IC; t++) drive_tile(pat, v, od, x, y);
  endtask

  task automatic push_group(input int pat, input int v, input logic [7:0] od,
                            input logic [8:0] x, input logic [8:0] y);
    exp_t e;
    int acc;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        acc = 0;
        for (int t = 0; t < NUM_IC; t++) acc = sat13(acc + tile_val(pat, v, r, c));
        e.v[c] = 13'(acc);
      end
      e.od = od; e.x = x; e.y = y + 9'(r); e.last = (r == 5);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_complete", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("idle_after_drain", 32'(out_valid_o), 32'd0);
  endtask

  // Monitor: compare every accepted row and check stalled rows stay put.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        bad = !out_valid_o || (out_od_o !== prev_od) || (out_x_o !== prev_x) ||
              (out_y_o !== prev_y) || (out_last_o !== prev_last);
        for (int c = 0; c < 6; c++) if (out_row_o[c] !== prev_row[c]) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL hold_stable got valid=%0d y=%0d e0=%0d want valid=1 y=%0d e0=%0d",
                   out_valid_o, out_y_o, out_row_o[0], prev_y, prev_row[0]);
        end
      end
      if (out_valid_o && out_ready_i) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_row got y=%0d od=%0d want no row", out_y_o, out_od_o);
        end else begin
          mon_e = exp_q.pop_front();
          rows_seen++;
          bad = 1'b0;
          for (int c = 0; c < 6; c++) if (out_row_o[c] !== mon_e.v[c]) bad = 1'b1;
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL row_data y=%0d got %0d %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d %0d",
                     mon_e.y, out_row_o[0], out_row_o[1], out_row_o[2], out_row_o[3],
                     out_row_o[4], out_row_o[5],
                     $signed(mon_e.v[0]), $signed(mon_e.v[1]), $signed(mon_e.v[2]),
                     $signed(mon_e.v[3]), $signed(mon_e.v[4]), $signed(mon_e.v[5]));
          end
          checks++;
          if (out_od_o !== mon_e.od || out_x_o !== mon_e.x || out_y_o !== mon_e.y ||
              out_last_o !== mon_e.last) begin
            errors++;
            $display("FAIL row_tag got od=%0d x=%0d y=%0d last=%0d want od=%0d x=%0d y=%0d last=%0d",
                     out_od_o, out_x_o, out_y_o, out_last_o,
                     mon_e.od, mon_e.x, mon_e.y, mon_e.last);
          end
        end
      end else if (out_valid_o) begin
        held = 1'b1;
        for (int c = 0; c < 6; c++) prev_row[c] = out_row_o[c];
        prev_od = out_od_o; prev_x = out_x_o; prev_y = out_y_o; prev_last = out_last_o;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    result_valid_i = 1'b0;
    out_ready_i = 1'b1;
    result_od_i = 8'd0; result_x_i = 9'd0; result_y_i = 9'd0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) result_tile_i[r][c] = 12'sd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_last", 32'(out_last_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_tag_err", 32'(tag_err_o), 32'd0);
    check("rst_od", 32'(out_od_o), 32'd0);
    check("rst_row0", 32'(out_row_o[0]), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: four all-ones tiles -> rows of 4, y 15..20
    push_group(0, 1, 8'd3, 9'd10, 9'd15);
    send_group(0, 1, 8'd3, 9'd10, 9'd15);
    wait_drained(100);

    // 2: saturation at ACC_W=13, positive then negative
    push_group(0, 2047, 8'd5, 9'd20, 9'd30);
    push_group(0, -2048, 8'd6, 9'd21, 9'd31);
    send_group(0, 2047, 8'd5, 9'd20, 9'd30);
    send_group(0, -2048, 8'd6, 9'd21, 9'd31);
    wait_drained(100);

    // position-dependent tile values to catch row/column mixups
    push_group(1, 0, 8'd7, 9'd100, 9'd200);
    send_group(1, 0, 8'd7, 9'd100, 9'd200);
    wait_drained(100);
    check("no_overflow_yet", 32'(overflow_o), 32'd0);

    // 3: stalled output, third group dropped, then 12 rows without a gap
    out_ready_i = 1'b0;
    push_group(0, 1, 8'd1, 9'd1, 9'd1);
    push_group(0, 2, 8'd2, 9'd2, 9'd2);
    send_group(0, 1, 8'd1, 9'd1, 9'd1);
    send_group(0, 2, 8'd2, 9'd2, 9'd2);
    send_group(0, 3, 8'd9, 9'd9, 9'd9);
    repeat (2) @(posedge clk);
    #1;
    check("t3_overflow", 32'(overflow_o), 32'd1);
    check("t3_stalled_valid", 32'(out_valid_o), 32'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t3_no_gap", 32'(out_valid_o), 32'd1);
    end
    @(negedge clk);
    check("t3_idle", 32'(out_valid_o), 32'd0);
    check("t3_all_rows", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // 4: ready toggling every cycle -> 6 rows in 12 cycles
    out_ready_i = 1'b0;
    push_group(0, 3, 8'd4, 9'd40, 9'd50);
    send_group(0, 3, 8'd4, 9'd40, 9'd50);
    n = 0;
    while (!out_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_valid_seen", 32'(out_valid_o), 32'd1);
    for (int i = 0; i < 12; i++) begin
      out_ready_i = (i % 2 == 1);
      @(posedge clk); #1;
    end
    check("t4_done_valid", 32'(out_valid_o), 32'd0);
    check("t4_done_rows", 32'(exp_q.size()), 32'd0);
    out_ready_i = 1'b1;

    // 6: second tile carries a different od
    check("t6_tag_err_before", 32'(tag_err_o), 32'd0);
    push_group(0, 1, 8'd3, 9'd10, 9'd15);
    drive_tile(0, 1, 8'd3, 9'd10, 9'd15);
    drive_tile(0, 1, 8'd4, 9'd10, 9'd15);
    drive_tile(0, 1, 8'd3, 9'd10, 9'd15);
    drive_tile(0, 1, 8'd3, 9'd10, 9'd15);
    wait_drained(100);
    check("t6_tag_err", 32'(tag_err_o), 32'd1);

    // 5: reset while row 3 is pending and a partial group is in the other bank
    out_ready_i = 1'b0;
    push_group(0, 2, 8'd8, 9'd60, 9'd70);
    send_group(0, 2, 8'd8, 9'd60, 9'd70);
    n = 0;
    while (!out_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    drive_tile(0, 7, 8'd11, 9'd12, 9'd13);
    check("t5_row3_pending", 32'(out_y_o), 32'd73);
    check("t5_overflow_set", 32'(overflow_o), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_valid_cleared", 32'(out_valid_o), 32'd0);
    check("t5_overflow_cleared", 32'(overflow_o), 32'd0);
    check("t5_tag_err_cleared", 32'(tag_err_o), 32'd0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    push_group(0, 5, 8'd11, 9'd12, 9'd13);
    send_group(0, 5, 8'd11, 9'd12, 9'd13);
    wait_drained(100);

    check("rows_total", 32'(rows_seen), 32'd57);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
